// File: rtl/memory_arbiter.sv
// Two-requester RAM-port arbiter: data has priority, and a streak limiter makes sure fetch is not starved.
// Define ARB_STATS_EN to add the icount/dcount/istall statistics counters.
module memory_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int WORD_W      = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
`ifdef ARB_STATS_EN
    input  logic [1:0]        ramstate,
    output logic [31:0]       icount,
    output logic [31:0]       dcount,
    output logic [31:0]       istall
`else
    input  logic [1:0]        ramstate
`endif
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, IGNT, DGNT, RETRY} state_t;

    state_t            state_q;
    logic              en_q;
    logic              op_ren_q;
    logic              op_wen_q;
    logic              ret_data_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] store_q;
    logic [SW-1:0]     dstreak_q;

    logic i_done;
    logic d_done;
    logic d_req;
    logic streak_full;

    always_comb begin
        i_done      = (state_q == IGNT) && (ramstate == RS_ACCESS);
        d_done      = (state_q == DGNT) && (ramstate == RS_ACCESS);
        d_req       = dREN | dWEN;
        streak_full = (dstreak_q == STREAK_MAX);
    end

    assign iwait    = ~i_done;
    assign dwait    = ~d_done;
    assign iload    = i_done ? ramload : '0;
    assign dload    = d_done ? ramload : '0;
    assign ramREN   = en_q & op_ren_q;
    assign ramWEN   = en_q & op_wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    // The operation and address are latched at grant time, so a requester that
    // drops its request mid-grant cannot disturb the access in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            op_ren_q   <= 1'b0;
            op_wen_q   <= 1'b0;
            ret_data_q <= 1'b0;
            addr_q     <= '0;
            store_q    <= '0;
            dstreak_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!iREN)
                        dstreak_q <= '0;
                    if (d_req && !(iREN && streak_full)) begin
                        state_q    <= DGNT;
                        en_q       <= 1'b1;
                        op_ren_q   <= dREN & ~dWEN;
                        op_wen_q   <= dWEN;
                        ret_data_q <= 1'b1;
                        addr_q     <= daddr;
                        store_q    <= dstore;
                    end else if (iREN) begin
                        state_q    <= IGNT;
                        en_q       <= 1'b1;
                        op_ren_q   <= 1'b1;
                        op_wen_q   <= 1'b0;
                        ret_data_q <= 1'b0;
                        addr_q     <= iaddr;
                    end
                end
                IGNT, DGNT: begin
                    if (ramstate == RS_ACCESS) begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                        if (state_q == IGNT)
                            dstreak_q <= '0;
                        else if (iREN && !streak_full)
                            dstreak_q <= dstreak_q + SW'(1);
                    end else if (ramstate == RS_ERROR) begin
                        state_q <= RETRY;
                        en_q    <= 1'b0;
                    end
                end
                RETRY: begin
                    state_q <= ret_data_q ? DGNT : IGNT;
                    en_q    <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] icount_q;
    logic [31:0] dcount_q;
    logic [31:0] istall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            icount_q <= '0;
            dcount_q <= '0;
            istall_q <= '0;
        end else begin
            if (i_done)
                icount_q <= icount_q + 32'd1;
            if (d_done)
                dcount_q <= dcount_q + 32'd1;
            if (iREN && iwait)
                istall_q <= istall_q + 32'd1;
        end
    end

    assign icount = icount_q;
    assign dcount = dcount_q;
    assign istall = istall_q;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (default parameters, MAX_DSTREAK=4).
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN;
`ifdef ARB_STATS_EN
    logic [31:0] icount, dcount, istall;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    memory_arbiter dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload),
`ifdef ARB_STATS_EN
        .ramstate(ramstate), .icount(icount), .dcount(dcount), .istall(istall)
`else
        .ramstate(ramstate)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [9:0] pat;
    logic       is_d;

    initial begin
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;

        // Reset held for two cycles
        tick(); tick();
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        RST = 1'b0;
        tick();

        // Single instruction fetch, RAM answers immediately
        iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
        #1;
        chk("ifetch_idle_iwait", 32'(iwait), 32'd1);
        tick();
        chk("ifetch_ramREN", 32'(ramREN), 32'd1);
        chk("ifetch_ramaddr", ramaddr, 32'h40);
        chk("ifetch_iwait", 32'(iwait), 32'd0);
        chk("ifetch_iload", iload, 32'hDEAD_BEEF);
        chk("ifetch_dwait", 32'(dwait), 32'd1);
        iREN = 0;
        tick();
        chk("ifetch_done_ramREN", 32'(ramREN), 32'd0);
        chk("ifetch_done_iwait", 32'(iwait), 32'd1);

        // Simultaneous fetch and data write: data wins
        iREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h1234; ramstate = BUSY;
        tick();
        chk("sim_ramWEN", 32'(ramWEN), 32'd1);
        chk("sim_ramREN", 32'(ramREN), 32'd0);
        chk("sim_ramaddr", ramaddr, 32'h80);
        chk("sim_ramstore", ramstore, 32'h1234);
        chk("sim_busy_dwait", 32'(dwait), 32'd1);
        chk("sim_busy_iwait", 32'(iwait), 32'd1);
        ramstate = ACCESS;
        #1;
        chk("sim_dwait", 32'(dwait), 32'd0);
        chk("sim_iwait", 32'(iwait), 32'd1);
        dWEN = 0;
        tick();
        chk("sim_idle_iwait", 32'(iwait), 32'd1);
        tick();
        ramload = 32'h11;
        #1;
        chk("sim_i_ramREN", 32'(ramREN), 32'd1);
        chk("sim_i_ramaddr", ramaddr, 32'h40);
        chk("sim_i_iwait", 32'(iwait), 32'd0);
        chk("sim_i_iload", iload, 32'h11);
        iREN = 0;
        tick();

        // Both held: streak limiter gives D,D,D,D,I,D,D,D,D,I (bit k = 1 for data)
        pat = 10'b0111101111;
        iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h80; ramstate = ACCESS;
        for (int k = 0; k < 10; k++) begin
            tick();
            is_d = pat[k];
            chk($sformatf("streak%0d_ramaddr", k), ramaddr, is_d ? 32'h80 : 32'h40);
            chk($sformatf("streak%0d_dwait", k), 32'(dwait), is_d ? 32'd0 : 32'd1);
            chk($sformatf("streak%0d_iwait", k), 32'(iwait), is_d ? 32'd1 : 32'd0);
            if (k != 9)
                tick();
        end
        iREN = 0; dREN = 0;
        tick();

        // ERROR during a data read: one RETRY cycle, then reissue
        dREN = 1; daddr = 32'h90; ramstate = BUSY;
        tick();
        chk("err_ramREN", 32'(ramREN), 32'd1);
        chk("err_dwait_busy", 32'(dwait), 32'd1);
        ramstate = ERROR;
        #1;
        chk("err_dwait_error", 32'(dwait), 32'd1);
        tick();
        ramstate = BUSY;
        #1;
        chk("retry_ramREN", 32'(ramREN), 32'd0);
        chk("retry_ramWEN", 32'(ramWEN), 32'd0);
        chk("retry_dwait", 32'(dwait), 32'd1);
        tick();
        chk("reissue_ramREN", 32'(ramREN), 32'd1);
        chk("reissue_ramaddr", ramaddr, 32'h90);
        chk("reissue_dwait", 32'(dwait), 32'd1);
        ramstate = ACCESS; ramload = 32'h55;
        #1;
        chk("reissue_done_dwait", 32'(dwait), 32'd0);
        chk("reissue_dload", dload, 32'h55);
        dREN = 0;
        tick();

        // Request dropped mid-grant keeps the access; reset then abandons it
        dREN = 1; daddr = 32'hA0; ramstate = BUSY;
        tick();
        dREN = 0;
        #1;
        chk("drop_ramREN", 32'(ramREN), 32'd1);
        chk("drop_ramaddr", ramaddr, 32'hA0);
        RST = 1;
        tick();
        chk("midrst_ramREN", 32'(ramREN), 32'd0);
        chk("midrst_ramWEN", 32'(ramWEN), 32'd0);
        chk("midrst_dwait", 32'(dwait), 32'd1);
        ramstate = ACCESS;
        #1;
        chk("midrst_access_dwait", 32'(dwait), 32'd1);
`ifdef ARB_STATS_EN
        chk("midrst_dcount", dcount, 32'd0);
`endif
        RST = 0;
        tick();
        chk("post_rst_idle_ramREN", 32'(ramREN), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
